// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared definitions for the push-button / switch conditioning blocks.
//   - state_t : 2-bit debounce FSM encodings
//   - DEF_*   : default parameter values used by btn_debounce
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_PEND_HI   = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_PEND_LO   = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_LONG_CYCLES   = 10;
    localparam int DEF_LONG_W        = 26;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input bit. Both stages
//   clear to 0 on reset. Reusable by any block that samples a board pin.
// Ports
//   clk    in  system clock (posedge)
//   reset  in  synchronous, active-high
//   d      in  asynchronous input
//   q      out synchronized output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions a raw button/switch pin: synchronizes it into clk, requires a
//   new level to persist STABLE_CYCLES consecutive cycles before committing,
//   and produces a registered clean level plus one-cycle rise/fall pulses.
//   Clean input change to btn_level change is STABLE_CYCLES+2 edges.
//
//   Optional feature macro: BTN_DEBOUNCE_LONGPRESS_EN
//     defined     : long_press asserts once btn_level has been high for
//                   LONG_CYCLES edges, drops with btn_level.
//     not defined : long_press tied 0, no long-press counter.
// Ports
//   clk         in   system clock (posedge)
//   reset       in   synchronous, active-high; dominates everything
//   btn_in      in   raw asynchronous pin
//   btn_level   out  debounced level
//   rise_pulse  out  one-cycle pulse when btn_level goes 0->1
//   fall_pulse  out  one-cycle pulse when btn_level goes 1->0
//   long_press  out  held high while press exceeds LONG_CYCLES
// -----------------------------------------------------------------------------
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int LONG_W        = DEF_LONG_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic long_press
);

    // Elaboration-time sanity of the configuration.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("btn_debounce: STABLE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("btn_debounce: LONG_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // ---------------------------------------------------------------------
    // Synchronizer: s2 is the only btn_in-derived signal the FSM sees
    // ---------------------------------------------------------------------
    logic s2;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (s2)
    );

    // ---------------------------------------------------------------------
    // Debounce FSM + stability counter
    // ---------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (s2 != level_q) begin
            if (cnt_q == CNT_LAST) begin
                // New level has persisted long enough: commit and pulse.
                level_d = s2;
                rise_d  = s2;
                fall_d  = ~s2;
                cnt_d   = '0;
                state_d = s2 ? ST_STABLE_HI : ST_STABLE_LO;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = s2 ? ST_PEND_HI : ST_PEND_LO;
            end
        end else begin
            // Input agrees with committed level: any pending change was bounce.
            cnt_d   = '0;
            state_d = level_q ? ST_STABLE_HI : ST_STABLE_LO;
        end

        // Keep the state/level pairing consistent even from an unexpected
        // state value: level is high exactly in STABLE_HI / PEND_LO.
        if ((state_q == ST_STABLE_HI || state_q == ST_PEND_LO) != level_q) begin
            state_d = level_q ? ST_STABLE_HI : ST_STABLE_LO;
            cnt_d   = '0;
        end
    end

    assign btn_level  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    // ---------------------------------------------------------------------
    // Optional long-press detector
    // ---------------------------------------------------------------------
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] lcnt_q, lcnt_d;
    logic              long_q;

    // Counting only starts the edge after btn_level rose (needs level_q and
    // level_d both high), so long_press lands LONG_CYCLES edges after the
    // rise. Using level_d for the clear makes long_press drop in the very
    // cycle btn_level falls.
    always_comb begin
        lcnt_d = '0;
        if (level_q && level_d) begin
            lcnt_d = (lcnt_q == LONG_MAX) ? lcnt_q : lcnt_q + LONG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            long_q <= (lcnt_d == LONG_MAX);
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Directed, table-driven bench for btn_debounce at STABLE_CYCLES=4,
//   LONG_CYCLES=10. Each table row is one clock: inputs applied before the
//   edge, outputs compared 1 time unit after it. Long-press behaviour is
//   covered by a hand-written sequence that follows the build macro.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic rise_pulse;
    logic fall_pulse;
    logic long_press;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .STABLE_CYCLES (4),
        .CNT_W         (16),
        .LONG_CYCLES   (10),
        .LONG_W        (26)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .long_press (long_press)
    );

    typedef struct packed {
        logic btn;
        logic rst;
        logic lvl;
        logic rise;
        logic fall;
        logic lp;
    } vec_t;

    vec_t tbl[$];

    task automatic push(input logic b, input logic r, input logic l,
                        input logic ri, input logic fa, input int n);
        vec_t v;
        v.btn = b; v.rst = r; v.lvl = l; v.rise = ri; v.fall = fa; v.lp = 1'b0;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check4(input string name, input logic l, input logic ri,
                          input logic fa, input logic lp);
        checks++;
        if ({btn_level, rise_pulse, fall_pulse, long_press} !== {l, ri, fa, lp}) begin
            failures++;
            $display("FAIL %s: got lvl/rise/fall/long=%b%b%b%b expected %b%b%b%b",
                     name, btn_level, rise_pulse, fall_pulse, long_press, l, ri, fa, lp);
        end
    endtask

    task automatic step(input logic b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  n;
        bit  seen;

        reset  = 1'b1;
        btn_in = 1'b0;

        // ---- build vector table ------------------------------------------
        // 1. reset 2 cycles, then quiet low for 20
        push(0, 1, 0, 0, 0, 2);
        push(0, 0, 0, 0, 0, 20);
        // 2. clean rise: commit on the 6th edge
        push(1, 0, 0, 0, 0, 5);
        push(1, 0, 1, 1, 0, 1);
        push(1, 0, 1, 0, 0, 3);
        // 4. clean fall
        push(0, 0, 1, 0, 0, 5);
        push(0, 0, 0, 0, 1, 1);
        push(0, 0, 0, 0, 0, 3);
        // 3. bounce: 1 x3, 0 x1 (arrives just as cnt hits 3), then 1 held
        push(1, 0, 0, 0, 0, 3);
        push(0, 0, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 5);
        push(1, 0, 1, 1, 0, 1);
        push(1, 0, 1, 0, 0, 2);
        // back low
        push(0, 0, 1, 0, 0, 5);
        push(0, 0, 0, 0, 1, 1);
        push(0, 0, 0, 0, 0, 3);
        // 5. btn high, reset when cnt=2: no pulse, rise 6 edges after reset
        push(1, 0, 0, 0, 0, 4);
        push(1, 1, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 5);
        push(1, 0, 1, 1, 0, 1);
        push(1, 0, 1, 0, 0, 2);
        // reset while committed high: level cleared, no fall pulse
        push(1, 1, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 5);
        push(1, 0, 1, 1, 0, 1);
        // reset with btn low to park the design
        push(0, 1, 0, 0, 0, 2);

        // ---- apply table -------------------------------------------------
        foreach (tbl[i]) begin
            step(tbl[i].btn, tbl[i].rst);
            check4($sformatf("vec[%0d]", i), tbl[i].lvl, tbl[i].rise,
                   tbl[i].fall, tbl[i].lp);
        end

        // ---- 6. long-press sequence --------------------------------------
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1, 0);
            if (btn_level) begin
                n    = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || n != 6 || !rise_pulse) begin
            failures++;
            $display("FAIL lp_rise_latency: got edges=%0d rise=%b expected edges=6 rise=1",
                     n, rise_pulse);
        end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        for (int k = 1; k <= 13; k++) begin
            step(1, 0);
            check4($sformatf("lp_hold[%0d]", k), 1'b1, 1'b0, 1'b0, (k >= 10));
        end
        for (int k = 1; k <= 5; k++) begin
            step(0, 0);
            check4($sformatf("lp_release[%0d]", k), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        step(0, 0);
        check4("lp_fall", 1'b0, 1'b0, 1'b1, 1'b0);
`else
        for (int k = 1; k <= 13; k++) begin
            step(1, 0);
            check4($sformatf("lp_hold[%0d]", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 5; k++) begin
            step(0, 0);
            check4($sformatf("lp_release[%0d]", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(0, 0);
        check4("lp_fall", 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        step(0, 0);
        check4("lp_after_fall", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
